rr_packet_arbiter: RTL
======================

Name: rr_packet_arbiter

Overview:
Parametrised N-way round-robin arbiter for the router's output-port allocation stage. Grants one of NUM_REQ requesters and holds the grant across a whole packet until the granted requester's tail flit is acknowledged. It then re-arbitrates with the just-served requester at lowest priority. Registered outputs, rotating-pointer fairness, back-to-back packet handoff with no bubble.

Parameters:
NUM_REQ, 5, number of requesters (N, S, E, W, local); legal range 2..16
IDX_W, $clog2(NUM_REQ), width of grant index (derived localparam, not overridable)
TIMEOUT_CYCLES, 64, lock watchdog limit; used only with RR_ARB_TIMEOUT_EN

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester head-flit valid
req_tail  input  NUM_REQ  per-requester flag: current head flit is the packet tail (single-flit packet = head and tail)
ack  input  1  downstream accepted the flit of the granted requester this cycle
grant  output  NUM_REQ  one-hot grant, registered
grant_idx  output  IDX_W  binary index of the granted requester, registered
grant_valid  output  1  a grant is held
timeout  output  1  one-cycle pulse on forced release; constant 0 without RR_ARB_TIMEOUT_EN

Behaviour:
- Reset (reset==0, async): grant=0, grant_idx=0, grant_valid=0, timeout=0, state=IDLE, ptr=0. Requester 0 has top priority after reset.
- ptr = index with highest priority. Pick = first i with req[i]==1, scanning ptr, ptr+1, ... modulo NUM_REQ.
- IDLE: if |req, then grant, grant_idx and grant_valid are loaded with the pick at the next edge and state goes to LOCKED. Latency is 1 cycle from req to grant. If req==0, stay IDLE with outputs at 0.
- LOCKED: grant is held unchanged regardless of other req changes.
  - Release event: ack && req_tail[grant_idx].
  - On release, ptr <= (grant_idx+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
  - In the same cycle, pick with the new ptr value over current req. This includes the released requester, which is now lowest priority.
  - If any requester is pending, load the new grant and stay LOCKED (no bubble). Otherwise clear outputs and go to IDLE.
  - ack without req_tail: no state change (body flit).
  - Granted req drops while LOCKED (protocol violation): treated as release. ptr advances and re-arbitration happens as above.
- ack while grant_valid==0 is ignored.
- Only one grant bit is ever high; grant_valid == |grant; grant_idx is consistent with grant.
- Simultaneous new requests arriving during LOCKED are queued only by req staying high; the arbiter stores no request history.

Optional Feature:
Macro RR_ARB_TIMEOUT_EN.
- With it: an 8-bit-or-wider counter (width $clog2(TIMEOUT_CYCLES+1)) clears on every grant load and on ack, and increments each LOCKED cycle without ack.
  - When it reaches TIMEOUT_CYCLES, force a release (same ptr and re-arbitration rules) and pulse timeout high for 1 cycle.
  - Counter resets asynchronously to 0.
- Without it: no counter; timeout is tied to 0; lock is unbounded.

Decomposition:
- Shared package noc_arb_pkg:
  - NUM_PORTS=5
  - port index constants PORT_LOCAL=0, PORT_NORTH=1, PORT_EAST=2, PORT_SOUTH=3, PORT_WEST=4
  - state enum {IDLE, LOCKED}
  - function for one-hot-to-index
- Sub-module rr_pick: purely combinational rotating-priority picker.
  - Inputs: req, ptr. Outputs: any, pick_idx, pick_onehot.
  - Implemented by a double-width request vector and masked priority encode.
  - Instantiated once; the FSM and registers stay in rr_packet_arbiter.

Test Plan:
- Reset and single request: NUM_REQ=5, reset low then high, req=5'b00100 → grant=5'b00100, grant_idx=2 one cycle later. Then ack with req_tail[2]=1 and req=0 → next cycle grant=0, grant_valid=0, ptr=3.
- Round-robin fairness: req=5'b11111 held, every packet single-flit (req_tail=all 1, ack every cycle) → grant_idx sequence 0,1,2,3,4,0 with no idle cycle between grants.
- Packet lock: requester 1 granted with 4-flit packet (tail on 4th ack), req[3] raised on cycle 2 → grant stays 5'b00010 for all 4 flits, then switches to 5'b01000 the cycle after the tail ack.
- Wrap and self-lowest-priority: last grant idx=4, req=5'b10001 on release → next grant idx=0. Release 0 with req=5'b10001 → next grant idx=4.
- Reset mid-packet: assert reset while grant_idx=3 LOCKED → grant, grant_valid immediately 0 (async). After release, req=5'b11000 → grant_idx=3 (ptr back to 0).
- RR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: grant idx=2 held, no ack for 8 cycles, req=5'b00110 → timeout pulses one cycle, grant moves to idx=1 (ptr=3 wraps past 4, 0 to reach 1).

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-port allocation logic:
// port numbering, arbiter state encoding and a one-hot to index helper.
package noc_arb_pkg;

    localparam int NUM_PORTS  = 5;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_WEST  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Binary index of the set bit in a one-hot vector of up to 16 bits.
    // An all-zero vector maps to index 0.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker. The request vector is duplicated
// so that a scan starting at ptr and wrapping past NUM_REQ-1 becomes a plain
// lowest-set-bit search over the masked upper part of the doubled vector.
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   pick_idx,
    output logic [NUM_REQ-1:0] pick_onehot
);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] masked_req;
    logic                 found;

    assign any = |req;

    // Mask off positions below ptr in the doubled vector, then take the
    // first remaining request and fold its position back into 0..NUM_REQ-1.
    always_comb begin
        dbl_req     = {req, req};
        masked_req  = '0;
        found       = 1'b0;
        pick_onehot = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            masked_req[i] = dbl_req[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (!found && masked_req[i]) begin
                found = 1'b1;
                pick_onehot[(i >= NUM_REQ) ? (i - NUM_REQ) : i] = 1'b1;
            end
        end
    end

    assign pick_idx = IDX_W'(onehot_to_idx(16'(pick_onehot)));

endmodule

// File: rtl/rr_packet_arbiter.sv
// Packet-granular round-robin arbiter for output-port allocation.
// A grant is held for a whole packet and released on the tail-flit ack
// (or when the granted requester drops its request); the just-served
// requester then becomes lowest priority and a new grant, if any request is
// pending, is loaded in the same cycle so packets follow back to back.
// Optional lock watchdog: define RR_ARB_TIMEOUT_EN to force a release after
// TIMEOUT_CYCLES locked cycles without ack; otherwise timeout stays 0.
module rr_packet_arbiter
    import noc_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 5,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_tail,
    input  logic               ack,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rr_packet_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   pick_ptr;
    logic               rel_evt;
    logic               load_grant;
    logic               force_rel;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    // Release and re-arbitration decision; while locked the picker already
    // sees the post-release pointer so the handoff needs no extra cycle.
    always_comb begin
        next_ptr   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        rel_evt    = (state == LOCKED) &&
                     ((ack && req_tail[grant_idx]) || !req[grant_idx] || force_rel);
        pick_ptr   = (state == LOCKED) ? next_ptr : ptr;
        load_grant = pick_any && ((state == IDLE) || rel_evt);
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req         (req),
        .ptr         (pick_ptr),
        .any         (pick_any),
        .pick_idx    (pick_idx),
        .pick_onehot (pick_onehot)
    );

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_NAT = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_NAT > 8) ? CNT_NAT : 8;

    logic [CNT_W-1:0] lock_cnt;

    assign force_rel = (state == LOCKED) && (lock_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Watchdog: counts locked cycles without downstream progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt <= '0;
        end else if (load_grant || ack) begin
            lock_cnt <= '0;
        end else if (state == LOCKED) begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // Arbitration FSM with registered grant outputs and rotating pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_grant) begin
                        grant       <= pick_onehot;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        state       <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (rel_evt) begin
                        ptr     <= next_ptr;
                        timeout <= force_rel;
                        if (load_grant) begin
                            grant       <= pick_onehot;
                            grant_idx   <= pick_idx;
                            grant_valid <= 1'b1;
                        end else begin
                            grant       <= '0;
                            grant_idx   <= '0;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
